// File: rtl/multi_iter_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : multi_iter_if                                           |
// | Purpose  : operand / product handshake bundle for multi_iter       |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
interface multi_iter_if #(
    parameter int DATA_WIDTH = 512
);
    logic                       in_valid;
    logic                       in_ready;
    logic [DATA_WIDTH-1:0]      dat1;
    logic [DATA_WIDTH-1:0]      dat2;
    logic                       op_signed;
    logic                       out_valid;
    logic                       out_ready;
    logic [2*DATA_WIDTH-1:0]    product;
    logic                       busy;

    modport master (
        output in_valid, dat1, dat2, op_signed, out_ready,
        input  in_ready, out_valid, product, busy
    );

    modport slave (
        input  in_valid, dat1, dat2, op_signed, out_ready,
        output in_ready, out_valid, product, busy
    );
endinterface
`default_nettype wire

// File: rtl/multi_iter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : multi_iter                                              |
// | Purpose  : iterative DATA x LIMB multiplier, unsigned or signed    |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
module multi_iter #(
    parameter int DATA_WIDTH = 512,
    parameter int LIMB_WIDTH = 64
) (
    input  wire logic       clk,
    input  wire logic       rst,
    multi_iter_if.slave     bus
);
    localparam int c_n_limbs = DATA_WIDTH / LIMB_WIDTH;
    localparam int c_cnt_w   = $clog2(c_n_limbs);
    localparam int c_n_pad   = 1 << c_cnt_w;
    localparam int c_prod_w  = 2 * DATA_WIDTH;
    localparam int c_sh_w    = $clog2(c_prod_w);
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(c_n_limbs - 1);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_calc = 2'd1;
    localparam logic [1:0] c_st_fix  = 2'd2;
    localparam logic [1:0] c_st_done = 2'd3;

    logic [1:0]                 state_q, state_d;
    logic [c_cnt_w-1:0]         cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]      a_q, a_d;
    logic [DATA_WIDTH-1:0]      b_q, b_d;
    logic                       sgn_q, sgn_d;
    logic [c_prod_w-1:0]        acc_q, acc_d;

    logic [LIMB_WIDTH-1:0]              w_limbs [c_n_pad];
    logic [LIMB_WIDTH-1:0]              w_limb;
    logic [DATA_WIDTH+LIMB_WIDTH-1:0]   w_pp;
    logic [c_sh_w-1:0]                  w_sh;
    logic [c_prod_w-1:0]                w_pp_sh;
    logic [c_prod_w-1:0]                w_fix_a;
    logic [c_prod_w-1:0]                w_fix_b;

    // Limb table padded to a power of two so the counter never indexes past it.
    for (genvar g = 0; g < c_n_pad; g++) begin : g_limb
        if (g < c_n_limbs) begin : g_live
            assign w_limbs[g] = b_q[g*LIMB_WIDTH +: LIMB_WIDTH];
        end else begin : g_pad
            assign w_limbs[g] = '0;
        end
    end

    assign w_limb  = w_limbs[cnt_q];
    assign w_pp    = {{LIMB_WIDTH{1'b0}}, a_q} * {{DATA_WIDTH{1'b0}}, w_limb};
    assign w_sh    = c_sh_w'(cnt_q) * c_sh_w'(LIMB_WIDTH);
    assign w_pp_sh = {{(DATA_WIDTH-LIMB_WIDTH){1'b0}}, w_pp} << w_sh;

    // Two's-complement correction of the unsigned product: subtract the
    // other operand, weighted by 2^DATA_WIDTH, for each negative operand.
    assign w_fix_a = a_q[DATA_WIDTH-1] ? {b_q, {DATA_WIDTH{1'b0}}} : '0;
    assign w_fix_b = b_q[DATA_WIDTH-1] ? {a_q, {DATA_WIDTH{1'b0}}} : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= c_st_idle;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sgn_q   <= 1'b0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sgn_q   <= sgn_d;
            acc_q   <= acc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            c_st_idle: if (bus.in_valid)       state_d = c_st_calc;
            c_st_calc: if (cnt_q == c_last)    state_d = c_st_fix;
            c_st_fix:                          state_d = c_st_done;
            c_st_done: if (bus.out_ready)      state_d = c_st_idle;
            default:                           state_d = c_st_idle;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        a_d   = a_q;
        b_d   = b_q;
        sgn_d = sgn_q;
        acc_d = acc_q;
        case (state_q)
            c_st_idle: begin
                if (bus.in_valid) begin
                    a_d   = bus.dat1;
                    b_d   = bus.dat2;
                    sgn_d = bus.op_signed;
                    acc_d = '0;
                    cnt_d = '0;
                end
            end
            c_st_calc: begin
                acc_d = acc_q + w_pp_sh;
                cnt_d = cnt_q + c_cnt_w'(1);
            end
            c_st_fix: begin
                if (sgn_q) begin
                    acc_d = acc_q - w_fix_a - w_fix_b;
                end
            end
            default: begin
                acc_d = acc_q;
            end
        endcase
    end

    always_comb begin
        bus.in_ready  = (state_q == c_st_idle);
        bus.out_valid = (state_q == c_st_done);
        bus.busy      = (state_q != c_st_idle);
        bus.product   = acc_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_multi_iter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : tb_multi_iter                                           |
// | Purpose  : self-checking bench, 16/4 and 512/64 multi_iter configs |
// | Revision : 1.0                                                     |
// +--------------------------------------------------------------------+
module tb_multi_iter;
    localparam int WS = 16;
    localparam int LS = 4;
    localparam int NS = 4;
    localparam int WB = 512;
    localparam int LB = 64;
    localparam int NB = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    multi_iter_if #(.DATA_WIDTH(WS)) bs ();
    multi_iter_if #(.DATA_WIDTH(WB)) bb ();

    multi_iter #(.DATA_WIDTH(WS), .LIMB_WIDTH(LS)) u_small (.clk(clk), .rst(rst), .bus(bs));
    multi_iter #(.DATA_WIDTH(WB), .LIMB_WIDTH(LB)) u_big   (.clk(clk), .rst(rst), .bus(bb));

    // index 0 = small config, index 1 = default config
    logic           drv_iv [2];
    logic           drv_or [2];
    logic           drv_sg [2];
    logic [511:0]   drv_d1 [2];
    logic [511:0]   drv_d2 [2];
    logic           mon_ir [2];
    logic           mon_ov [2];
    logic           mon_bz [2];
    logic [1023:0]  mon_pr [2];

    assign bs.in_valid  = drv_iv[0];
    assign bs.out_ready = drv_or[0];
    assign bs.op_signed = drv_sg[0];
    assign bs.dat1      = drv_d1[0][WS-1:0];
    assign bs.dat2      = drv_d2[0][WS-1:0];
    assign bb.in_valid  = drv_iv[1];
    assign bb.out_ready = drv_or[1];
    assign bb.op_signed = drv_sg[1];
    assign bb.dat1      = drv_d1[1];
    assign bb.dat2      = drv_d2[1];

    assign mon_ir[0] = bs.in_ready;
    assign mon_ov[0] = bs.out_valid;
    assign mon_bz[0] = bs.busy;
    assign mon_pr[0] = {{(1024-2*WS){1'b0}}, bs.product};
    assign mon_ir[1] = bb.in_ready;
    assign mon_ov[1] = bb.out_valid;
    assign mon_bz[1] = bb.busy;
    assign mon_pr[1] = bb.product;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string nm, input logic [1023:0] act, input logic [1023:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            if (act[1023:800] == '0 && want[1023:800] == '0)
                $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, want);
            else
                $display("FAIL %s: got low800 0x%h want low800 0x%h", nm, act[799:0], want[799:0]);
        end
    endtask

    // Exact product: sign/zero-extend both operands to 2w bits and keep the low 2w bits.
    function automatic logic [1023:0] ref_mul(input logic [511:0] a, input logic [511:0] b,
                                              input bit s, input int w);
        logic [1023:0] m1, m2, ea, eb;
        m1 = (1024'(1) << w) - 1024'(1);
        m2 = (1024'(1) << (2*w)) - 1024'(1);
        ea = {512'b0, a} & m1;
        eb = {512'b0, b} & m1;
        if (s && ea[w-1]) ea = ea | ~m1;
        if (s && eb[w-1]) eb = eb | ~m1;
        return (ea * eb) & m2;
    endfunction

    function automatic logic [511:0] rand_op(input int w);
        logic [511:0] v, m;
        m = (512'(1) << w) - 512'(1);
        case ($urandom_range(0, 7))
            0:       v = '0;
            1:       v = m;
            2:       v = (m >> 1) + 512'(1);
            3:       v = m >> 1;
            default: for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom;
        endcase
        return v & m;
    endfunction

    // Transaction-level model: a transaction accepted in cycle t must show
    // out_valid from cycle t+N+2 until the cycle its out_ready handshake completes.
    bit             pend   [2];
    bit             zero_f [2];
    int             acc_t  [2];
    logic [1023:0]  exp_p  [2];
    bit             armed = 1'b0;
    int             t = 0;

    always @(negedge clk) begin : p_model
        int n;
        bit ev;
        for (int k = 0; k < 2; k++) begin
            n  = (k == 0) ? NS : NB;
            ev = pend[k] && (t >= acc_t[k] + n + 2);
            if (armed) begin
                check($sformatf("m%0d in_ready", k),  1024'(mon_ir[k]), 1024'(!pend[k]));
                check($sformatf("m%0d busy", k),      1024'(mon_bz[k]), 1024'(pend[k]));
                check($sformatf("m%0d out_valid", k), 1024'(mon_ov[k]), 1024'(ev));
                if (ev)        check($sformatf("m%0d product", k), mon_pr[k], exp_p[k]);
                if (zero_f[k]) check($sformatf("m%0d reset product", k), mon_pr[k], '0);
            end
            if (rst) begin
                pend[k]   = 1'b0;
                zero_f[k] = 1'b1;
            end else if (!pend[k] && drv_iv[k]) begin
                pend[k]   = 1'b1;
                zero_f[k] = 1'b0;
                acc_t[k]  = t;
                exp_p[k]  = ref_mul(drv_d1[k], drv_d2[k], drv_sg[k], (k == 0) ? WS : WB);
            end else if (ev && drv_or[k]) begin
                pend[k] = 1'b0;
            end
        end
        if (rst) armed = 1'b1;
        t++;
    end

    task automatic run_txn(input int k, input logic [511:0] a, input logic [511:0] b,
                           input bit s, input bit lit, input logic [1023:0] want,
                           input int lat_exp, input int hold, input bit scram, input string nm);
        int n, w, lat, waitc;
        n = (k == 0) ? NS : NB;
        w = (k == 0) ? WS : WB;
        @(posedge clk); #1;
        drv_d1[k] = a;
        drv_d2[k] = b;
        drv_sg[k] = s;
        drv_iv[k] = 1'b1;
        drv_or[k] = (hold == 0);
        waitc = 0;
        do begin
            @(negedge clk);
            waitc++;
        end while (!mon_ir[k] && waitc < 20);
        check({nm, " accept"}, 1024'(mon_ir[k]), 1024'(1));
        @(posedge clk); #1;
        drv_iv[k] = 1'b0;
        if (scram) begin
            drv_d1[k] = ~a;
            drv_d2[k] = ~b;
            drv_sg[k] = ~s;
        end
        lat = 0;
        forever begin
            @(negedge clk);
            lat++;
            if (mon_ov[k] || lat >= 60) break;
            @(posedge clk); #1;
            if (scram) begin
                drv_d1[k] = rand_op(w);
                drv_d2[k] = rand_op(w);
                drv_sg[k] = ~drv_sg[k];
                drv_iv[k] = (lat < n) ? 1'($urandom_range(0, 1)) : 1'b0;
            end
        end
        check({nm, " latency"}, 1024'(lat), 1024'(lat_exp));
        if (lit) check({nm, " product"}, mon_pr[k], want);
        if (hold > 0) begin
            for (int h = 1; h < hold; h++) begin
                @(posedge clk); #1;
                @(negedge clk);
                check({nm, " hold out_valid"}, 1024'(mon_ov[k]), 1024'(1));
                check({nm, " hold in_ready"},  1024'(mon_ir[k]), 1024'(0));
                if (lit) check({nm, " hold product"}, mon_pr[k], want);
            end
            @(posedge clk); #1;
            drv_or[k] = 1'b1;
            @(negedge clk);
            check({nm, " release out_valid"}, 1024'(mon_ov[k]), 1024'(1));
        end
        @(posedge clk); #1;
        drv_or[k] = 1'b0;
        @(negedge clk);
        check({nm, " idle in_ready"},  1024'(mon_ir[k]), 1024'(1));
        check({nm, " idle out_valid"}, 1024'(mon_ov[k]), 1024'(0));
    endtask

    initial begin : p_stim
        logic [511:0]  a_big;
        logic [1023:0] e_big;
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            drv_iv[k] = 1'b0;
            drv_or[k] = 1'b0;
            drv_sg[k] = 1'b0;
            drv_d1[k] = '0;
            drv_d2[k] = '0;
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check($sformatf("reset%0d in_ready", k),  1024'(mon_ir[k]), 1024'(1));
            check($sformatf("reset%0d out_valid", k), 1024'(mon_ov[k]), 1024'(0));
            check($sformatf("reset%0d busy", k),      1024'(mon_bz[k]), 1024'(0));
            check($sformatf("reset%0d product", k),   mon_pr[k], '0);
        end

        run_txn(0, 512'hFFFF, 512'hFFFF, 1'b0, 1'b1, 1024'hFFFE0001, 6, 0, 1'b0, "s_u_ones");
        run_txn(0, 512'h0,    512'h1234, 1'b0, 1'b1, 1024'h0,        6, 0, 1'b0, "s_u_zero");
        run_txn(0, 512'hFFFF, 512'hFFFF, 1'b1, 1'b1, 1024'h00000001, 6, 0, 1'b0, "s_s_m1m1");
        run_txn(0, 512'h8000, 512'h8000, 1'b1, 1'b1, 1024'h40000000, 6, 0, 1'b0, "s_s_minmin");
        run_txn(0, 512'h0003, 512'hFFFE, 1'b1, 1'b1, 1024'hFFFFFFFA, 6, 0, 1'b0, "s_s_3m2");
        run_txn(0, 512'h8000, 512'h7FFF, 1'b1, 1'b1, 1024'hC0008000, 6, 0, 1'b0, "s_s_minmax");
        run_txn(0, 512'h1234, 512'h5678, 1'b0, 1'b1, 1024'h06260060, 6, 5, 1'b1, "s_bp_u");
        run_txn(0, 512'hFFF0, 512'h0010, 1'b1, 1'b1, 1024'hFFFFFF00, 6, 2, 1'b1, "s_bp_s");

        // reset in the middle of CALC
        @(posedge clk); #1;
        drv_d1[0] = 512'h1234;
        drv_d2[0] = 512'h4321;
        drv_sg[0] = 1'b0;
        drv_iv[0] = 1'b1;
        drv_or[0] = 1'b1;
        @(negedge clk);
        check("rstmid accept", 1024'(mon_ir[0]), 1024'(1));
        @(posedge clk); #1;
        drv_iv[0] = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rstmid in_ready",  1024'(mon_ir[0]), 1024'(1));
        check("rstmid out_valid", 1024'(mon_ov[0]), 1024'(0));
        check("rstmid product",   mon_pr[0], '0);
        repeat (12) begin
            @(negedge clk);
            check("rstmid no out_valid", 1024'(mon_ov[0]), 1024'(0));
        end
        drv_or[0] = 1'b0;
        run_txn(0, 512'h00FF, 512'h0101, 1'b0, 1'b1, 1024'hFFFF, 6, 0, 1'b0, "s_after_rst");

        a_big = '0;
        a_big[511] = 1'b1;
        e_big = '0;
        e_big[1022] = 1'b1;
        run_txn(1, a_big, a_big, 1'b0, 1'b1, e_big, 10, 0, 1'b0, "b_u_pow");
        a_big = '1;
        e_big = {{511{1'b1}}, {512{1'b0}}, 1'b1};
        run_txn(1, a_big, a_big, 1'b0, 1'b1, e_big, 10, 0, 1'b0, "b_u_ones");
        run_txn(1, a_big, a_big, 1'b1, 1'b1, 1024'(1), 10, 3, 1'b1, "b_s_m1m1");

        for (int i = 0; i < 2000; i++) begin
            repeat ($urandom_range(0, 2)) @(posedge clk);
            run_txn(0, rand_op(WS), rand_op(WS), 1'($urandom_range(0, 1)), 1'b0, '0,
                    6, $urandom_range(0, 3), 1'($urandom_range(0, 1)), "s_rand");
        end
        for (int i = 0; i < 30; i++) begin
            run_txn(1, rand_op(WB), rand_op(WB), 1'($urandom_range(0, 1)), 1'b0, '0,
                    10, $urandom_range(0, 3), 1'($urandom_range(0, 1)), "b_rand");
        end

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : p_watchdog
        #4000000;
        $display("FAIL watchdog: got no finish, want finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
